// File: rtl/word_serializer_pkg.sv
// Shared encodings and defaults for the word serializer.
// Also used by the register bank and display blocks.
package word_serializer_pkg;

  localparam int WORD_W  = 16;
  localparam int BIT_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic int hold_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word handshake in, serial bit stream out.
// Producer side is master, serializer side is slave.
interface word_serializer_if
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;
  logic             sdo;
  logic             bit_stb;
  logic             busy;
  logic             done;

  modport master (
    output d, d_valid,
    input  d_ready, sdo, bit_stb, busy, done
  );

  modport slave (
    input  d, d_valid,
    output d_ready, sdo, bit_stb, busy, done
  );

endinterface

// File: rtl/word_serializer_bit_timer.sv
// Per-bit hold counter, frozen while i_en is low.
// o_first marks the first cycle of a bit, o_tc its last enabled cycle.
module bit_timer
  import word_serializer_pkg::*;
#(
  parameter int DIV = BIT_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_load,
  input  logic i_run,
  output logic o_tc,
  output logic o_first
);

  localparam int HW = hold_w(DIV);
  localparam logic [HW-1:0] LAST = HW'(DIV - 1);

  logic [HW-1:0] r_hold;

  assign o_tc    = i_run & i_en & (r_hold == LAST);
  assign o_first = i_run & (r_hold == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold <= '0;
    end else if (i_en) begin
      if (i_load | o_tc) begin
        r_hold <= '0;
      end else if (i_run) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-in serial-out word transmitter, MSB first.
// Each bit is held DIV enabled cycles with a strobe on its first cycle.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIV   = BIT_DIV
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  word_serializer_if.slave   s_if
);

  localparam int BW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [BW-1:0]    r_bit;

  logic w_run;
  logic w_accept;
  logic w_tc;
  logic w_first;

  assign w_run    = (r_state == ST_SHIFT);
  assign w_accept = s_if.d_valid & s_if.d_ready;

  assign s_if.d_ready = (r_state == ST_IDLE) & i_en & ~i_rst;
  assign s_if.sdo     = w_run & r_sreg[WIDTH-1];
  assign s_if.bit_stb = w_first & i_en;
  assign s_if.busy    = w_run;
  assign s_if.done    = (r_state == ST_FINISH) & i_en;

  bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_load (w_accept),
    .i_run  (w_run),
    .o_tc   (w_tc),
    .o_first(w_first)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_bit   <= '0;
    end else if (i_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sreg  <= s_if.d;
            r_bit   <= BW'(WIDTH - 1);
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tc) begin
            if (r_bit == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
              r_bit  <= r_bit - 1'b1;
            end
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: DIV=4 and DIV=1 instances,
// scoreboard of words checked when DONE fires.
module tb_word_serializer;
  import word_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  word_serializer_if #(.WIDTH(16)) bus4 ();
  word_serializer_if #(.WIDTH(16)) bus1 ();

  word_serializer #(.WIDTH(16), .DIV(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .s_if(bus4)
  );

  word_serializer #(.WIDTH(16), .DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .s_if(bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    bus4.d = 16'hA5C3;
    bus4.d_valid = 1'b1;
    bus1.d = 16'h0000;
    bus1.d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      n_chk++;
      if ({bus4.sdo, bus4.busy, bus4.done, bus4.bit_stb, bus4.d_ready} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset4 cyc%0d: got %b want 00000", i,
          {bus4.sdo, bus4.busy, bus4.done, bus4.bit_stb, bus4.d_ready});
      end
      n_chk++;
      if ({bus1.sdo, bus1.busy, bus1.done, bus1.bit_stb, bus1.d_ready} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset1 cyc%0d: got %b want 00000", i,
          {bus1.sdo, bus1.busy, bus1.done, bus1.bit_stb, bus1.d_ready});
      end
    end
    @(posedge clk);
    #1;
    bus4.d_valid = 1'b0;
    bus1.d_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus4.d_ready, bus4.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: ready,busy got %b want 10",
        {bus4.d_ready, bus4.busy});
    end
  endtask

  task automatic xfer4(input logic [15:0] w, input int pause_at,
                       input int pause_len, input bit inject);
    int t;
    int c;
    int paused;
    int done_cyc;
    logic [15:0] rx;
    logic [15:0] q;
    logic e_sdo, e_stb, e_busy, e_done;
    t = 1;
    c = 0;
    paused = 0;
    done_cyc = -1;
    rx = '0;
    bus4.d = w;
    bus4.d_valid = 1'b1;
    n_chk++;
    if (bus4.d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: got %b want 1", bus4.d_ready);
    end
    sb_q.push_back(w);
    while (t <= 66 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      bus4.d_valid = inject && c >= 10 && c <= 40;
      bus4.d = inject ? 16'hFFFF : 16'h0F0F;
      en = !(t == pause_at && paused < pause_len);
      if (!en) paused++;
      #1;
      e_busy = (t <= 64);
      e_sdo  = e_busy ? w[15 - (t - 1) / 4] : 1'b0;
      e_stb  = en && e_busy && ((t - 1) % 4 == 0);
      e_done = en && (t == 65);
      if (t == 66) begin
        n_chk++;
        if ({bus4.d_ready, bus4.busy} !== 2'b10) begin
          n_fail++;
          $display("FAIL ready_after_done c%0d: ready,busy got %b want 10",
            c, {bus4.d_ready, bus4.busy});
        end
      end else begin
        n_chk++;
        if ({bus4.sdo, bus4.bit_stb, bus4.busy, bus4.done, bus4.d_ready} !==
            {e_sdo, e_stb, e_busy, e_done, 1'b0}) begin
          n_fail++;
          $display("FAIL xfer4 c%0d t%0d: sdo,stb,busy,done,rdy got %b want %b",
            c, t, {bus4.sdo, bus4.bit_stb, bus4.busy, bus4.done, bus4.d_ready},
            {e_sdo, e_stb, e_busy, e_done, 1'b0});
        end
      end
      if (e_stb) rx = {rx[14:0], bus4.sdo};
      if (bus4.done === 1'b1) begin
        done_cyc = c;
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb4: done with empty scoreboard");
        end else begin
          q = sb_q.pop_front();
          if (rx !== q) begin
            n_fail++;
            $display("FAIL sb4 word: got %h want %h", rx, q);
          end
        end
      end
      if (en) t++;
    end
    en = 1'b1;
    bus4.d_valid = 1'b0;
    n_chk++;
    if (c >= 200 || done_cyc != 65 + pause_len) begin
      n_fail++;
      $display("FAIL done_cycle: got %0d want %0d", done_cyc, 65 + pause_len);
    end
  endtask

  task automatic test_nominal();
    xfer4(16'hA5C3, 0, 0, 1'b0);
  endtask

  task automatic test_busy_reject();
    xfer4(16'hA5C3, 0, 0, 1'b1);
  endtask

  task automatic test_en_pause();
    xfer4(16'h3C96, 22, 7, 1'b0);
  endtask

  task automatic test_mid_reset();
    int dones;
    bus4.d = 16'hFFFF;
    bus4.d_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      bus4.d_valid = 1'b0;
      if (c == 20) rst = 1'b1;
      #1;
    end
    n_chk++;
    if (bus4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: busy got %b want 1", bus4.busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus4.sdo, bus4.bit_stb, bus4.busy, bus4.done, bus4.d_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL midrst_post: sdo,stb,busy,done,rdy got %b want 00001",
        {bus4.sdo, bus4.bit_stb, bus4.busy, bus4.done, bus4.d_ready});
    end
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #2;
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) dones++;
    end
    n_chk++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL midrst_abandon: activity cycles got %0d want 0", dones);
    end
  endtask

  task automatic test_div1_back_to_back();
    int k;
    logic [15:0] cw;
    logic [15:0] rx;
    logic [15:0] q;
    logic e_sdo, e_busy, e_done, e_rdy;
    rx = '0;
    bus1.d = 16'h8001;
    bus1.d_valid = 1'b1;
    n_chk++;
    if (bus1.d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL div1_ready0: got %b want 1", bus1.d_ready);
    end
    sb_q.push_back(16'h8001);
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        bus1.d = 16'h1234;
        sb_q.push_back(16'h1234);
      end
      if (c == 19) bus1.d_valid = 1'b0;
      #1;
      if (c <= 17) begin
        k = c;
        cw = 16'h8001;
      end else begin
        k = c - 18;
        cw = 16'h1234;
      end
      e_busy = (k >= 1 && k <= 16);
      e_sdo  = e_busy ? cw[16 - k] : 1'b0;
      e_done = (k == 17);
      e_rdy  = (k == 0 || k == 18);
      n_chk++;
      if ({bus1.sdo, bus1.bit_stb, bus1.busy, bus1.done, bus1.d_ready} !==
          {e_sdo, e_busy, e_busy, e_done, e_rdy}) begin
        n_fail++;
        $display("FAIL div1 c%0d: sdo,stb,busy,done,rdy got %b want %b", c,
          {bus1.sdo, bus1.bit_stb, bus1.busy, bus1.done, bus1.d_ready},
          {e_sdo, e_busy, e_busy, e_done, e_rdy});
      end
      if (e_busy) rx = {rx[14:0], bus1.sdo};
      if (bus1.done === 1'b1) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb1: done with empty scoreboard");
        end else begin
          q = sb_q.pop_front();
          if (rx !== q) begin
            n_fail++;
            $display("FAIL sb1 word: got %h want %h", rx, q);
          end
        end
        rx = '0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_busy_reject();
    test_en_pause();
    test_mid_reset();
    test_div1_back_to_back();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d words left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
